bayer_to_gray: RTL and testbench

Streaming front-end stage that sits directly upstream of the 3x3 edge convolution.
- Accepts raw RGGB Bayer pixels from the camera capture path in raster order.
- Collapses each 2x2 Bayer quad into one grayscale sample.
- Emits the result as a valid-qualified stream of width DATA_WIDTH, at half horizontal and half vertical resolution, ready for the convolution input.

---
 rtl/bayer_to_gray.sv | 145 ++++++++++++++
 tb/tb_bayer_to_gray.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_to_gray.sv
// ---------------------------------------------------------------------------
// bayer_to_gray
//
// Streaming RGGB Bayer to grayscale reducer. Every 2x2 Bayer quad becomes
// one gray sample, so the output has half the horizontal and half the
// vertical resolution of the input. Feeds the 3x3 edge convolution.
//
// Even rows (R G1 R G1 ...) go into a one-line buffer. On odd rows
// (G2 B G2 B ...) the G2 pixel is held in a register until its B partner
// arrives. R and G1 are then read back from the line buffer and the quad
// is reduced.
//
// Optional feature macro: BAYER_LUMA_WEIGHT_EN
//   undefined : o_val = (R + G1 + G2 + B) >> 2
//   defined   : o_val = (5*R + 4*(G1+G2) + 3*B) >> 4
//
// Ports
//   i_clk          : clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   i_frame_start  : first pixel of a frame (only honoured with i_val_valid)
//   i_val_valid    : i_val carries a raw pixel this cycle
//   i_val          : raw Bayer sample, raster order
//   o_val_valid    : one-cycle strobe, o_val holds a new gray sample
//   o_val          : gray sample, holds its value between strobes
//   o_frame_done   : strobe on the last quad of a frame
// ---------------------------------------------------------------------------
module bayer_to_gray #(
   parameter int DATA_WIDTH = 12,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_frame_start,
   input  logic                  i_val_valid,
   input  logic [DATA_WIDTH-1:0] i_val,
   output logic                  o_val_valid,
   output logic [DATA_WIDTH-1:0] o_val,
   output logic                  o_frame_done
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]         col_cnt;
   logic [RW-1:0]         row_cnt;
   logic [DATA_WIDTH-1:0] held;
   logic [DATA_WIDTH-1:0] lbuf [IMG_WIDTH];

   // Position of the pixel on the input this cycle. A frame start pulse
   // overrides the counters so this pixel is taken as row 0, col 0.
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;
   logic [CW-1:0] prev_col;
   logic          row_odd;
   logic          col_odd;
   logic          quad_done;
   logic          last_quad;

   always_comb begin
      cur_col   = i_frame_start ? '0 : col_cnt;
      cur_row   = i_frame_start ? '0 : row_cnt;
      row_odd   = cur_row[0];
      col_odd   = cur_col[0];
      // cur_col is odd whenever prev_col is used, so no underflow.
      prev_col  = cur_col - CW'(1);
      quad_done = i_val_valid && row_odd && col_odd;
      last_quad = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
   end

   // Quad members. R/G1 come from the previous even row, G2 from the
   // held register, B is the incoming pixel.
   logic [DATA_WIDTH-1:0] px_r, px_g1, px_g2, px_b;
   logic [DATA_WIDTH-1:0] gray;

   always_comb begin
      px_r  = lbuf[prev_col];
      px_g1 = lbuf[cur_col];
      px_g2 = held;
      px_b  = i_val;
   end

`ifdef BAYER_LUMA_WEIGHT_EN
   // 5R + 4(G1+G2) + 3B built from shifts and adds. The sum of weights
   // is 16, so the result fits in DATA_WIDTH+4 bits.
   logic [DATA_WIDTH+3:0] wr, wg1, wg2, wb, wsum;
   always_comb begin
      wr   = (DATA_WIDTH+4)'(px_r);
      wg1  = (DATA_WIDTH+4)'(px_g1);
      wg2  = (DATA_WIDTH+4)'(px_g2);
      wb   = (DATA_WIDTH+4)'(px_b);
      wsum = (wr << 2) + wr + ((wg1 + wg2) << 2) + (wb << 1) + wb;
      gray = DATA_WIDTH'(wsum >> 4);
   end
`else
   logic [DATA_WIDTH+1:0] sum;
   always_comb begin
      sum  = (DATA_WIDTH+2)'(px_r) + (DATA_WIDTH+2)'(px_g1)
           + (DATA_WIDTH+2)'(px_g2) + (DATA_WIDTH+2)'(px_b);
      gray = DATA_WIDTH'(sum >> 2);
   end
`endif

   // Raster counters and held G2 pixel; all frozen on stall cycles.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         col_cnt <= '0;
         row_cnt <= '0;
         held    <= '0;
      end else if (i_val_valid) begin
         if (cur_col == COL_LAST) begin
            col_cnt <= '0;
            row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
         end else begin
            col_cnt <= cur_col + CW'(1);
            row_cnt <= cur_row;
         end
         if (row_odd && !col_odd)
            held <= i_val;
      end
   end

   // Line buffer: written on even rows only, contents need no reset.
   always_ff @(posedge i_clk) begin
      if (i_val_valid && !row_odd)
         lbuf[cur_col] <= i_val;
   end

   // Output register: one-cycle strobes, o_val holds between quads.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_val_valid  <= 1'b0;
         o_val        <= '0;
         o_frame_done <= 1'b0;
      end else begin
         o_val_valid  <= quad_done;
         o_frame_done <= quad_done && last_quad;
         if (quad_done)
            o_val <= gray;
      end
   end

endmodule

// File: tb/tb_bayer_to_gray.sv
module tb_bayer_to_gray;

   logic        clk;
   logic        rst_n;
   logic        frame_start;
   logic        val_valid;
   logic [11:0] val;

   // 4x2 instance
   logic        o_valid;
   logic [11:0] o_val;
   logic        o_done;
   // 4x4 instance
   logic        q_valid;
   logic [11:0] q_val;
   logic        q_done;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef BAYER_LUMA_WEIGHT_EN
   localparam logic [11:0] EXP0 = 12'd106;
   localparam logic [11:0] EXP1 = 12'd253;
`else
   localparam logic [11:0] EXP0 = 12'd105;
   localparam logic [11:0] EXP1 = 12'd245;
`endif

   logic [11:0] frame [8] = '{12'd100, 12'd200, 12'd300, 12'd400,
                              12'd40,  12'd80,  12'd120, 12'd160};

   bayer_to_gray #(.DATA_WIDTH(12), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
      .i_val_valid(val_valid), .i_val(val),
      .o_val_valid(o_valid), .o_val(o_val), .o_frame_done(o_done));

   bayer_to_gray #(.DATA_WIDTH(12), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
      .i_val_valid(val_valid), .i_val(val),
      .o_val_valid(q_valid), .o_val(q_val), .o_frame_done(q_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one pixel for one cycle; returns 1 time unit after the edge.
   task automatic px(input logic [11:0] v, input logic fs);
      val = v; val_valid = 1'b1; frame_start = fs;
      @(posedge clk); #1;
      val_valid = 1'b0; frame_start = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; val_valid = 1'b0; frame_start = 1'b0; val = '0;
      repeat (2) idle();
      n_checks++;
      if ({o_valid, o_val, o_done, q_valid, q_val, q_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_hold got %b/%0d/%b %b/%0d/%b want zeros",
                  o_valid, o_val, o_done, q_valid, q_val, q_done);
      end
      rst_n = 1'b1;
      idle();
      n_checks++;
      if ({o_valid, o_val, o_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_release got %b/%0d/%b want zeros", o_valid, o_val, o_done);
      end
   endtask

   task automatic test_plain();
      for (int i = 0; i < 8; i++) begin
         px(frame[i], i == 0);
         n_checks++;
         if (o_valid !== (i == 5 || i == 7)) begin
            n_fail++;
            $display("FAIL plain_valid[%0d] got %b want %b", i, o_valid, (i == 5 || i == 7));
         end
         if (i == 5 || i == 7) begin
            n_checks++;
            if (o_val !== ((i == 5) ? EXP0 : EXP1)) begin
               n_fail++;
               $display("FAIL plain_val[%0d] got %0d want %0d", i, o_val, (i == 5) ? EXP0 : EXP1);
            end
            n_checks++;
            if (o_done !== (i == 7)) begin
               n_fail++;
               $display("FAIL plain_done[%0d] got %b want %b", i, o_done, (i == 7));
            end
         end
      end
      idle();
      n_checks++;
      if (o_valid !== 1'b0 || o_val !== EXP1 || o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL plain_hold got %b/%0d/%b want 0/%0d/0", o_valid, o_val, o_done, EXP1);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 8; i++) begin
         int gaps;
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) begin
            idle();
            n_checks++;
            if (o_valid !== 1'b0 || o_done !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_gap[%0d] got %b/%b want 0/0", i, o_valid, o_done);
            end
         end
         px(frame[i], i == 0);
         n_checks++;
         if (o_valid !== (i == 5 || i == 7)) begin
            n_fail++;
            $display("FAIL stall_valid[%0d] got %b want %b", i, o_valid, (i == 5 || i == 7));
         end
         if (i == 5 || i == 7) begin
            n_checks++;
            if (o_val !== ((i == 5) ? EXP0 : EXP1) || o_done !== (i == 7)) begin
               n_fail++;
               $display("FAIL stall_out[%0d] got %0d/%b want %0d/%b", i, o_val, o_done,
                        (i == 5) ? EXP0 : EXP1, (i == 7));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int outs = 0;
      for (int i = 0; i < 32; i++) begin
         int k;
         logic exp_v;
         k = i % 16;
         exp_v = (k == 5 || k == 7 || k == 13 || k == 15);
         px(12'd4095, i == 0);
         n_checks++;
         if (q_valid !== exp_v) begin
            n_fail++;
            $display("FAIL b2b_valid[%0d] got %b want %b", i, q_valid, exp_v);
         end
         if (exp_v) begin
            outs++;
            n_checks++;
            if (q_val !== 12'd4095 || q_done !== (outs == 4 || outs == 8)) begin
               n_fail++;
               $display("FAIL b2b_out[%0d] got %0d/%b want 4095/%b", outs, q_val, q_done,
                        (outs == 4 || outs == 8));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) px(frame[i], i == 0);
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({o_valid, o_val, o_done} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_async got %b/%0d/%b want zeros", o_valid, o_val, o_done);
      end
      // Pixels presented during reset must be ignored.
      for (int i = 5; i < 8; i++) begin
         px(frame[i], 1'b0);
         n_checks++;
         if ({o_valid, o_val, o_done} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_hold[%0d] got %b/%0d/%b want zeros", i, o_valid, o_val, o_done);
         end
      end
      rst_n = 1'b1;
      // No frame start: reset alone must restart at row 0, col 0.
      for (int i = 0; i < 8; i++) begin
         px(frame[i], 1'b0);
         n_checks++;
         if (o_valid !== (i == 5 || i == 7)) begin
            n_fail++;
            $display("FAIL rstmid_valid[%0d] got %b want %b", i, o_valid, (i == 5 || i == 7));
         end
         n_checks++;
         if (o_val !== ((i < 5) ? 12'd0 : (i < 7) ? EXP0 : EXP1)) begin
            n_fail++;
            $display("FAIL rstmid_val[%0d] got %0d want %0d", i, o_val,
                     (i < 5) ? 12'd0 : (i < 7) ? EXP0 : EXP1);
         end
      end
   endtask

   task automatic test_resync();
      // Three-pixel partial frame, then a partial that reaches into row 1.
      for (int pass = 0; pass < 2; pass++) begin
         int npart;
         npart = (pass == 0) ? 3 : 5;
         for (int i = 0; i < npart; i++) begin
            px(frame[i] + 12'd7, i == 0);
            n_checks++;
            if (o_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL resync_partial[%0d/%0d] got %b want 0", pass, i, o_valid);
            end
         end
         for (int i = 0; i < 8; i++) begin
            px(frame[i], i == 0);
            n_checks++;
            if (o_valid !== (i == 5 || i == 7)) begin
               n_fail++;
               $display("FAIL resync_valid[%0d/%0d] got %b want %b", pass, i, o_valid,
                        (i == 5 || i == 7));
            end
            if (i == 5 || i == 7) begin
               n_checks++;
               if (o_val !== ((i == 5) ? EXP0 : EXP1) || o_done !== (i == 7)) begin
                  n_fail++;
                  $display("FAIL resync_out[%0d/%0d] got %0d/%b want %0d/%b", pass, i, o_val,
                           o_done, (i == 5) ? EXP0 : EXP1, (i == 7));
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_plain();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_resync();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
